// File: rtl/ntt_pkg.sv
// Shared constants, FSM encoding and helpers for the NTT butterfly scheduler.
package ntt_pkg;

    localparam int DEF_LOGN    = 12;
    localparam int DEF_N       = 1 << DEF_LOGN;
    localparam int DEF_BF_LAT  = 8;
    localparam int DEF_RAM_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Read-to-write distance: RAM read latency plus butterfly latency.
    function automatic int pipe_depth(input int ram_lat, input int bf_lat);
        return ram_lat + bf_lat;
    endfunction

    // Width of the stage output, enough to hold 0..logn-1.
    function automatic int stage_width(input int logn);
        return $clog2(logn) + 1;
    endfunction

    // Bank select of an address: pair members must always disagree here.
    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift register that carries {valid, addr_a, addr_b} from the
// read issue point to the write-back point.
module ntt_delay_line
    import ntt_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             inflight
);

    logic [WIDTH-1:0] sr [DEPTH];

    // Shift one slot per cycle; reset wipes every slot so no write survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

    // Flags valid entries still behind the output slot (more writes to come).
    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            inflight = inflight | sr[i][WIDTH-1];
        end
    end

endmodule

// File: rtl/ntt_butterfly_scheduler.sv
// Address/twiddle sequencer for an in-place radix-2 Cooley-Tukey forward NTT.
// Reads one butterfly pair per cycle and replays the same pair as a write
// PIPE cycles later; each stage drains fully before the next one reads.
module ntt_butterfly_scheduler
    import ntt_pkg::*;
#(
    parameter int  LOGN    = DEF_LOGN,
    parameter int  BF_LAT  = DEF_BF_LAT,
    parameter int  RAM_LAT = DEF_RAM_LAT,
    localparam int SW      = stage_width(LOGN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [SW-1:0]   stage,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic            tw_en,
    output logic [LOGN-1:0] tw_idx,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);

    localparam int PIPE = pipe_depth(RAM_LAT, BF_LAT);
    localparam int JW   = LOGN - 1;
    localparam int DW   = 1 + 2 * LOGN;
    localparam logic [JW-1:0] J_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

    state_t          state, state_next;
    logic [SW-1:0]   s, s_next;
    logic [JW-1:0]   j, j_next;
    logic            inflight;
    logic [DW-1:0]   dl_in, dl_out;

    logic [SW-1:0]   p;
    logic [LOGN-1:0] j_ext, low_mask, addr_a, addr_b, tw;

    // State, stage and butterfly counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            s     <= '0;
            j     <= '0;
        end else begin
            state <= state_next;
            s     <= s_next;
            j     <= j_next;
        end
    end

    // Next-state logic: run N/2 pairs, drain the pipe, then advance the stage.
    always_comb begin
        state_next = state;
        s_next     = s;
        j_next     = j;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    s_next     = '0;
                    j_next     = '0;
                end
            end
            ST_RUN: begin
                j_next = j + 1'b1;
                if (j == J_LAST) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!inflight) begin
                    if (s == S_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_RUN;
                        s_next     = s + 1'b1;
                        j_next     = '0;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pair addresses: insert a zero at bit p of j, partner sets that bit.
    always_comb begin
        p        = S_LAST - s;
        j_ext    = LOGN'(j);
        low_mask = (LOGN'(1) << p) - LOGN'(1);
        addr_a   = ((j_ext >> p) << (p + 1'b1)) | (j_ext & low_mask);
        addr_b   = addr_a | (LOGN'(1) << p);
        tw       = (LOGN'(1) << s) + (j_ext >> p);
    end

    // Outputs are forced to zero outside the states that own them.
    always_comb begin
        rd_en     = (state == ST_RUN);
        rd_addr_a = rd_en ? addr_a : '0;
        rd_addr_b = rd_en ? addr_b : '0;
        tw_en     = rd_en;
        tw_idx    = rd_en ? tw : '0;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        stage     = (state == ST_IDLE) ? '0 : s;
        dl_in     = {rd_en, rd_addr_a, rd_addr_b};
        wr_en     = dl_out[DW-1];
        wr_addr_a = dl_out[2*LOGN-1:LOGN];
        wr_addr_b = dl_out[LOGN-1:0];
    end

    ntt_delay_line #(
        .DEPTH (PIPE),
        .WIDTH (DW)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .din      (dl_in),
        .dout     (dl_out),
        .inflight (inflight)
    );

endmodule

// File: tb/tb_ntt_butterfly_scheduler.sv
// Directed bench: a small LOGN=3 instance checked cycle by cycle against
// hand-written pair tables, and a default-size instance checked for counts,
// bank parity and done timing.
module tb_ntt_butterfly_scheduler;
    import ntt_pkg::*;

    logic clk;
    logic rst;
    logic start_s;
    logic start_b;

    // Small instance: LOGN=3, PIPE=3, stage length 4+3=7 cycles
    logic       s_busy, s_done, s_rd_en, s_tw_en, s_wr_en;
    logic [2:0] s_stage, s_rd_a, s_rd_b, s_tw, s_wa, s_wb;

    // Default instance: LOGN=12, PIPE=10
    logic        b_busy, b_done, b_rd_en, b_tw_en, b_wr_en;
    logic [4:0]  b_stage;
    logic [11:0] b_rd_a, b_rd_b, b_tw, b_wa, b_wb;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2:0] ta [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd2, 3'd4, 3'd6};
    logic [2:0] tb [12] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd1, 3'd3, 3'd5, 3'd7};
    logic [2:0] tt [12] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    logic [22:0] obs_s;
    assign obs_s = {s_rd_en, s_rd_a, s_rd_b, s_tw_en, s_tw, s_wr_en, s_wa, s_wb,
                    s_done, s_busy, s_stage};

    ntt_butterfly_scheduler #(.LOGN(3), .BF_LAT(1), .RAM_LAT(2)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .busy(s_busy), .done(s_done),
        .stage(s_stage), .rd_en(s_rd_en), .rd_addr_a(s_rd_a), .rd_addr_b(s_rd_b),
        .tw_en(s_tw_en), .tw_idx(s_tw), .wr_en(s_wr_en), .wr_addr_a(s_wa),
        .wr_addr_b(s_wb)
    );

    ntt_butterfly_scheduler dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .done(b_done),
        .stage(b_stage), .rd_en(b_rd_en), .rd_addr_a(b_rd_a), .rd_addr_b(b_rd_b),
        .tw_en(b_tw_en), .tw_idx(b_tw), .wr_en(b_wr_en), .wr_addr_a(b_wa),
        .wr_addr_b(b_wb)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected small-instance output vector at cycle cyc after the accepting edge
    function automatic logic [22:0] exp_small(input int cyc);
        logic       rd, wr, dn, bz;
        logic [2:0] ra, rb, tw, wa, wb, stg;
        int         st, off, idx, c2;
        rd = 0; wr = 0; dn = 0; bz = 0;
        ra = 0; rb = 0; tw = 0; wa = 0; wb = 0; stg = 0;
        st  = (cyc - 1) / 7;
        off = (cyc - 1) % 7;
        if (cyc >= 1 && st < 3 && off < 4) begin
            idx = st * 4 + off;
            rd = 1; ra = ta[idx]; rb = tb[idx]; tw = tt[idx];
        end
        c2 = cyc - 3;
        if (c2 >= 1 && (c2 - 1) / 7 < 3 && (c2 - 1) % 7 < 4) begin
            idx = ((c2 - 1) / 7) * 4 + (c2 - 1) % 7;
            wr = 1; wa = ta[idx]; wb = tb[idx];
        end
        dn = (cyc == 22);
        bz = (cyc >= 1 && cyc <= 22);
        if (bz) stg = 3'(st > 2 ? 2 : st);
        return {rd, ra, rb, rd, tw, wr, wa, wb, dn, bz, stg};
    endfunction

    // Optionally pulse start, then compare cycles 1..last_cyc; start is
    // re-asserted during cycle extra_cyc to probe that it is ignored.
    task automatic applyStimulus(input bit pulse, input int extra_cyc, input int last_cyc);
        if (pulse) begin
            start_s = 1'b1;
            @(negedge clk);
        end
        for (int cyc = 1; cyc <= last_cyc; cyc++) begin
            start_s = (cyc == extra_cyc);
            checkOutput($sformatf("small cyc %0d", cyc), 64'(obs_s), 64'(exp_small(cyc)));
            @(negedge clk);
        end
        start_s = 1'b0;
    endtask

    // Full default-size transform with counters
    task automatic run_big();
        int rd_cnt = 0, wr_cnt = 0, tw_cnt = 0, done_cnt = 0, done_cyc = 0, par_bad = 0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int cyc = 1; cyc <= 24710; cyc++) begin
            if (b_rd_en) begin
                rd_cnt++;
                if (parity(32'(b_rd_a)) == parity(32'(b_rd_b))) par_bad++;
            end
            if (b_tw_en) tw_cnt++;
            if (b_wr_en) begin
                wr_cnt++;
                if (parity(32'(b_wa)) == parity(32'(b_wb))) par_bad++;
            end
            if (b_done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            @(negedge clk);
        end
        checkOutput("big rd count",   64'(rd_cnt),   64'd24576);
        checkOutput("big wr count",   64'(wr_cnt),   64'd24576);
        checkOutput("big tw count",   64'(tw_cnt),   64'd24576);
        checkOutput("big parity bad", 64'(par_bad),  64'd0);
        checkOutput("big done cycle", 64'(done_cyc), 64'd24697);
        checkOutput("big done width", 64'(done_cnt), 64'd1);
        checkOutput("big idle after", 64'({b_busy, b_stage}), 64'd0);
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        start_s = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("small in reset", 64'(obs_s), 64'd0);
        checkOutput("big in reset", 64'({b_rd_en, b_rd_a, b_rd_b, b_tw_en, b_tw, b_wr_en,
                                         b_wa, b_wb, b_done, b_busy, b_stage}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("small idle", 64'(obs_s), 64'd0);

        $display("[TB] plain run");
        applyStimulus(1'b1, 0, 26);
        $display("[TB] start pulsed at cycle 5");
        applyStimulus(1'b1, 5, 24);
        $display("[TB] start pulsed in the done cycle");
        applyStimulus(1'b1, 22, 30);
        $display("[TB] back-to-back start after done");
        applyStimulus(1'b1, 0, 22);
        applyStimulus(1'b1, 0, 26);

        $display("[TB] reset during stage 1");
        applyStimulus(1'b1, 0, 10);
        rst = 1'b1;
        #1;
        checkOutput("small async rst", 64'(obs_s), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("small post-rst %0d", k), 64'(obs_s), 64'd0);
            @(negedge clk);
        end
        applyStimulus(1'b1, 0, 24);

        $display("[TB] default-size run");
        run_big();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
